// File: rtl/crp16_alu_serial_cmp_if.sv
// Request/result bundle for the serial comparator: start/busy request side,
// valid/ready result side and the comparison flags.
interface crp16_alu_serial_cmp_if;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        us_s;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic        x_s;
    logic        y_s;
    logic        z_s;
    logic        c_out;
    logic [15:0] is_less;
    logic        is_eq;

    modport master (
        output start, x, y, us_s, res_ready,
        input  busy, res_valid, x_s, y_s, z_s, c_out, is_less, is_eq
    );

    modport slave (
        input  start, x, y, us_s, res_ready,
        output busy, res_valid, x_s, y_s, z_s, c_out, is_less, is_eq
    );
endinterface

// File: rtl/crp16_alu_serial_cmp.sv
// Area-reduced 16-bit comparator: computes x + ~y + 1 a chunk at a time from
// the LSB and reports the set-less-than flags, less-than result and equality.

module crp16_cmp_chunk #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero
);
    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign sum  = full[W-1:0];
    assign cout = full[W];
    assign zero = (full[W-1:0] == '0);
endmodule

module crp16_alu_serial_cmp #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    crp16_alu_serial_cmp_if.slave bus
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = 16 / B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_cfg
            $error("crp16_alu_serial_cmp: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [15:0]   diff_q, diff_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xs_q, xs_d;
    logic          ys_q, ys_d;
    logic          us_q, us_d;
    logic          x_s_q, x_s_d;
    logic          y_s_q, y_s_d;
    logic          z_s_q, z_s_d;
    logic          c_out_q, c_out_d;
    logic          is_eq_q, is_eq_d;
    logic          lt_q, lt_d;

    logic [B-1:0]  ch_sum;
    logic          ch_cout;
    logic          ch_zero;
    logic [15:0]   diff_shift;
    logic          last;

    crp16_cmp_chunk #(.W(B)) u_chunk (
        .a    (a_q[B-1:0]),
        .b    (b_q[B-1:0]),
        .cin  (carry_q),
        .sum  (ch_sum),
        .cout (ch_cout),
        .zero (ch_zero)
    );

    // New chunk enters at the top; after N chunks the full difference is aligned.
    assign diff_shift = 16'({ch_sum, diff_q} >> B);
    assign last       = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        us_d    = us_q;
        x_s_d   = x_s_q;
        y_s_d   = y_s_q;
        z_s_d   = z_s_q;
        c_out_d = c_out_q;
        is_eq_d = is_eq_q;
        lt_d    = lt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = bus.x;
                    b_d     = ~bus.y;
                    xs_d    = bus.x[15];
                    ys_d    = bus.y[15];
                    us_d    = bus.us_s;
                    carry_d = 1'b1;
                    zero_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> B;
                b_d     = b_q >> B;
                diff_d  = diff_shift;
                carry_d = ch_cout;
                zero_d  = zero_q & ch_zero;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = ST_DONE;
                    c_out_d = ch_cout;
                    z_s_d   = diff_shift[15];
                    is_eq_d = zero_q & ch_zero;
                    x_s_d   = xs_q;
                    y_s_d   = ys_q;
                    // Signed: differing signs decide directly, else the
                    // difference cannot overflow and its sign is the answer.
                    lt_d    = us_q ? ((xs_q ^ ys_q) ? xs_q : diff_shift[15]) : ~ch_cout;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            us_q    <= 1'b0;
            x_s_q   <= 1'b0;
            y_s_q   <= 1'b0;
            z_s_q   <= 1'b0;
            c_out_q <= 1'b0;
            is_eq_q <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            us_q    <= us_d;
            x_s_q   <= x_s_d;
            y_s_q   <= y_s_d;
            z_s_q   <= z_s_d;
            c_out_q <= c_out_d;
            is_eq_q <= is_eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.x_s       = x_s_q;
    assign bus.y_s       = y_s_q;
    assign bus.z_s       = z_s_q;
    assign bus.c_out     = c_out_q;
    assign bus.is_eq     = is_eq_q;
    assign bus.is_less   = {15'b0, lt_q};
endmodule

// File: tb/tb_crp16_alu_serial_cmp.sv
// Bench for the serial comparator: three widths (1, 4, 16 bits per cycle)
// share one stimulus stream and are checked against an arithmetic model.
module tb_crp16_alu_serial_cmp;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        us_s;
    logic        res_ready;

    int n_cmp = 0;
    int n_bad = 0;

    crp16_alu_serial_cmp_if i1 ();
    crp16_alu_serial_cmp_if i4 ();
    crp16_alu_serial_cmp_if i16 ();

    assign i1.start = start;  assign i1.x = x;  assign i1.y = y;  assign i1.us_s = us_s;  assign i1.res_ready = res_ready;
    assign i4.start = start;  assign i4.x = x;  assign i4.y = y;  assign i4.us_s = us_s;  assign i4.res_ready = res_ready;
    assign i16.start = start; assign i16.x = x; assign i16.y = y; assign i16.us_s = us_s; assign i16.res_ready = res_ready;

    crp16_alu_serial_cmp #(.BITS_PER_CYCLE(1))  dut1  (.clk(clk), .reset(reset), .bus(i1.slave));
    crp16_alu_serial_cmp #(.BITS_PER_CYCLE(4))  dut4  (.clk(clk), .reset(reset), .bus(i4.slave));
    crp16_alu_serial_cmp #(.BITS_PER_CYCLE(16)) dut16 (.clk(clk), .reset(reset), .bus(i16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, res_valid, x_s, y_s, z_s, c_out, is_eq, is_less}
    function automatic logic [22:0] obs(int k);
        case (k)
            0:       return {i1.busy, i1.res_valid, i1.x_s, i1.y_s, i1.z_s, i1.c_out, i1.is_eq, i1.is_less};
            1:       return {i4.busy, i4.res_valid, i4.x_s, i4.y_s, i4.z_s, i4.c_out, i4.is_eq, i4.is_less};
            default: return {i16.busy, i16.res_valid, i16.x_s, i16.y_s, i16.z_s, i16.c_out, i16.is_eq, i16.is_less};
        endcase
    endfunction

    function automatic int nch(int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 1;
    endfunction

    function automatic logic [20:0] flags(logic xs, logic ys, logic zs, logic c, logic eq, logic lt);
        return {xs, ys, zs, c, eq, 15'b0, lt};
    endfunction

    // Reference: plain 16-bit arithmetic and native signed/unsigned compares.
    function automatic logic [20:0] model(logic [15:0] xa, logic [15:0] ya, logic sa);
        logic [15:0] d;
        logic        lt;
        d  = xa - ya;
        lt = sa ? ($signed(xa) < $signed(ya)) : (xa < ya);
        return flags(xa[15], ya[15], d[15], xa >= ya, xa == ya, lt);
    endfunction

    task automatic run_cmp(input logic [15:0] xa, input logic [15:0] ya, input logic sa,
                           input logic [20:0] want, input string tag, input bit do_ack);
        int lat[3];
        logic [22:0] o;
        lat = '{-1, -1, -1};
        @(negedge clk);
        x = xa; y = ya; us_s = sa; start = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; x = 16'($urandom); y = 16'($urandom); us_s = 1'($urandom);
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o[22] !== 1'b1) begin
                n_bad++; $display("FAIL %s busy_after_accept dut%0d: got %b want 1", tag, k, o[22]);
            end
        end
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                o = obs(k);
                if (lat[k] < 0 && o[21] === 1'b1) lat[k] = c;
            end
        end
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (lat[k] !== nch(k)) begin
                n_bad++; $display("FAIL %s latency dut%0d: got %0d want %0d", tag, k, lat[k], nch(k));
            end
            n_cmp++;
            if (o !== {2'b11, want}) begin
                n_bad++; $display("FAIL %s result dut%0d: got %h want %h", tag, k, o, {2'b11, want});
            end
        end
        if (do_ack) begin
            @(negedge clk); res_ready = 1'b1;
            @(posedge clk); #1; res_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                o = obs(k);
                n_cmp++;
                if (o !== {2'b00, want}) begin
                    n_bad++; $display("FAIL %s idle_hold dut%0d: got %h want %h", tag, k, o, {2'b00, want});
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [22:0] o;
        reset = 1'b1; start = 1'b0; x = 16'h0; y = 16'h0; us_s = 1'b0; res_ready = 1'b0;
        #3;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o !== 23'h0) begin
                n_bad++; $display("FAIL reset_async dut%0d: got %h want 0", k, o);
            end
        end
        @(negedge clk); start = 1'b1; x = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o !== 23'h0) begin
                n_bad++; $display("FAIL reset_held dut%0d: got %h want 0", k, o);
            end
        end
        @(negedge clk); start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_directed();
        run_cmp(16'h0001, 16'h0002, 1'b0, flags(0, 0, 1, 0, 0, 1), "borrow", 1);
        run_cmp(16'h8000, 16'h0001, 1'b1, flags(1, 0, 0, 1, 0, 1), "signed", 1);
        run_cmp(16'h8000, 16'h0001, 1'b0, flags(1, 0, 0, 1, 0, 0), "unsigned", 1);
        run_cmp(16'h1234, 16'h1234, 1'b0, flags(0, 0, 0, 1, 1, 0), "eq_u", 1);
        run_cmp(16'h1234, 16'h1234, 1'b1, flags(0, 0, 0, 1, 1, 0), "eq_s", 1);
        run_cmp(16'h7FFF, 16'hFFFF, 1'b1, flags(0, 1, 1, 0, 0, 0), "ovf", 1);
        run_cmp(16'h0000, 16'hFFFF, 1'b0, flags(0, 1, 0, 0, 0, 1), "min_max", 1);
    endtask

    task automatic test_random();
        logic [15:0] xa, ya;
        logic        sa;
        for (int i = 0; i < 24; i++) begin
            xa = 16'($urandom);
            ya = (i % 6 == 0) ? xa : 16'($urandom);
            if (i % 4 == 1) ya = {xa[15], ya[14:0]};
            sa = 1'($urandom);
            run_cmp(xa, ya, sa, model(xa, ya, sa), "random", 1);
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] want;
        logic [22:0] o;
        want = model(16'hC001, 16'h4002, 1'b1);
        run_cmp(16'hC001, 16'h4002, 1'b1, want, "bp", 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = (c == 2); x = 16'($urandom); y = 16'($urandom); us_s = 1'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                o = obs(k);
                n_cmp++;
                if (o !== {2'b11, want}) begin
                    n_bad++; $display("FAIL bp_hold dut%0d c%0d: got %h want %h", k, c, o, {2'b11, want});
                end
            end
        end
        @(negedge clk); start = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o !== {2'b00, want}) begin
                n_bad++; $display("FAIL bp_release dut%0d: got %h want %h", k, o, {2'b00, want});
            end
        end
        run_cmp(16'h00FF, 16'h0F00, 1'b0, model(16'h00FF, 16'h0F00, 1'b0), "bp_next", 1);
    endtask

    task automatic test_reset_mid();
        logic [22:0] o;
        @(negedge clk);
        x = 16'hAAAA; y = 16'h5555; us_s = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(posedge clk);
        #2; reset = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o !== 23'h0) begin
                n_bad++; $display("FAIL reset_mid dut%0d: got %h want 0", k, o);
            end
        end
        @(negedge clk); reset = 1'b0;
        run_cmp(16'h0005, 16'h0003, 1'b0, flags(0, 0, 0, 1, 0, 0), "after_reset", 1);
    endtask

    task automatic test_back_to_back();
        logic [20:0] wa, wb;
        logic [22:0] o;
        wa = model(16'h0100, 16'h0200, 1'b0);
        wb = model(16'hFFF0, 16'h0010, 1'b1);
        @(negedge clk);
        x = 16'h0100; y = 16'h0200; us_s = 1'b0; start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        o = obs(2);
        n_cmp++;
        if (o !== {2'b11, wa}) begin
            n_bad++; $display("FAIL b2b_first: got %h want %h", o, {2'b11, wa});
        end
        @(negedge clk); x = 16'hFFF0; y = 16'h0010; us_s = 1'b1;
        @(posedge clk); #1;
        o = obs(2);
        n_cmp++;
        if (o[22:21] !== 2'b00) begin
            n_bad++; $display("FAIL b2b_handshake: got %b want 00", o[22:21]);
        end
        @(posedge clk); #1;
        o = obs(2);
        n_cmp++;
        if (o[22:21] !== 2'b10) begin
            n_bad++; $display("FAIL b2b_accept: got %b want 10", o[22:21]);
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        o = obs(2);
        n_cmp++;
        if (o !== {2'b11, wb}) begin
            n_bad++; $display("FAIL b2b_second: got %h want %h", o, {2'b11, wb});
        end
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            n_cmp++;
            if (o !== {2'b00, (k == 2) ? wb : wa}) begin
                n_bad++; $display("FAIL b2b_drain dut%0d: got %h want %h", k, o, {2'b00, (k == 2) ? wb : wa});
            end
        end
        @(negedge clk); res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/crp16_alu_serial_cmp.md
# crp16_alu_serial_cmp

Multi-cycle, area-reduced comparator that produces the adder-side flag bits (x_s, y_s, z_s, c_out) consumed by the ALU set-less-than logic. It also produces the final 16-bit less-than result and an equality flag. It computes x − y as x + ~y + 1, processing BITS_PER_CYCLE bits per clock from the LSB upward. Requests use a start/busy handshake and results use a valid/ready handshake. It sits beside the combinational ALU for low-area builds and multi-cycle compare/branch paths.

## Interface
- BITS_PER_CYCLE, default 1: bits of the difference computed per clock. Legal values: 1, 2, 4, 8, 16. Any other value is a static configuration error.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE.
- x  in  16  first operand; sampled on the accept edge.
- y  in  16  second operand; sampled on the accept edge.
- us_s  in  1  compare mode, sampled on the accept edge: 0 = unsigned, 1 = signed.
- busy  out  1  high in RUN and DONE.
- res_valid  out  1  high in DONE.
- res_ready  in  1  consumer accepts the result.
- x_s  out  1  bit 15 of the latched x.
- y_s  out  1  bit 15 of the latched y.
- z_s  out  1  bit 15 of x − y.
- c_out  out  1  carry out of x + ~y + 1. A value of 1 means no borrow.
- is_less  out  16  {15'b0, lt}.
- is_eq  out  1  high when x == y.

## Operation
- N = 16 / BITS_PER_CYCLE chunks per compare.
- States:
  - IDLE → RUN on start = 1. On that edge:
    - latch a = x and b = ~y;
    - store x[15] and y[15];
    - latch us_s;
    - set carry = 1, chunk count = 0, zero_acc = 1.
  - RUN, each edge:
    - sum the low BITS_PER_CYCLE bits of a and b with carry;
    - shift the sum into the top of the difference register;
    - shift a and b right by BITS_PER_CYCLE;
    - carry ← chunk carry-out;
    - zero_acc ← zero_acc AND (chunk sum == 0);
    - count increments.
  - RUN → DONE on the edge that processes chunk N−1. On that edge the flag outputs load:
    - c_out = final carry;
    - z_s = difference bit 15;
    - is_eq = final zero_acc;
    - x_s and y_s from the stored sign bits.
  - DONE → IDLE on res_valid AND res_ready.
- lt rule:
  - us_s = 0: lt = ~c_out.
  - us_s = 1: lt = (x_s ^ y_s) ? x_s : z_s.
- start is ignored in RUN and DONE, including in the DONE cycle where res_ready = 1. No request is queued.
- Inputs x, y and us_s are don't-care outside the accept edge.
- Flag outputs, is_less and is_eq change only on the RUN→DONE edge and on reset. They hold their last result through IDLE until the next compare completes.

## Timing
- Reset values: state = IDLE; busy, res_valid, x_s, y_s, z_s, c_out and is_eq = 0; is_less = 16'h0000. Outputs take these values immediately on reset assertion, without waiting for a clock edge.
- Reset during RUN or DONE aborts the operation: no res_valid is produced and the result is lost. The first edge after reset deassertion may accept a new start.
- Latency: accept on edge E0; res_valid and valid flags appear after edge E0 + N (BITS_PER_CYCLE = 1: 16 cycles; BITS_PER_CYCLE = 16: 1 cycle).
- busy rises after E0 and falls after the handshake edge.
- res_valid is held, with flags stable, for any number of cycles while res_ready = 0.
- Minimum issue interval is N + 2 cycles with res_ready tied high: accept, N RUN edges, then the handshake edge (DONE→IDLE). The next start is accepted on the following edge.
- res_ready while not in DONE has no effect.

## Test plan
- Unsigned borrow: BITS_PER_CYCLE = 1, x = 0x0001, y = 0x0002, us_s = 0.
  - res_valid appears 16 cycles after accept.
  - Required: z_s = 1, c_out = 0, is_less = 0x0001, is_eq = 0.
- Signed vs unsigned: x = 0x8000, y = 0x0001.
  - us_s = 1 → is_less = 0x0001 (x_s = 1, y_s = 0).
  - us_s = 0 → is_less = 0x0000 (c_out = 1, z_s = 0).
- Equality: x = y = 0x1234, any mode → is_eq = 1, is_less = 0x0000, c_out = 1, z_s = 0.
- Signed overflow: BITS_PER_CYCLE = 16, x = 0x7FFF, y = 0xFFFF, us_s = 1.
  - res_valid appears 1 cycle after accept.
  - Required: z_s = 1, x_s = 0, y_s = 1, is_less = 0x0000.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid, and pulse start during that time.
  - res_valid, busy and all flags stay constant; start is ignored.
  - Raising res_ready gives IDLE on the next edge, then a new compare completes normally.
- Reset mid-operation: BITS_PER_CYCLE = 1, assert reset 7 cycles after accept.
  - busy, res_valid and all flags drop to 0 immediately.
  - After release, x = 0x0005, y = 0x0003, us_s = 0 yields is_less = 0x0000, c_out = 1 after 16 cycles.
